// File: rtl/hwpe_ctrl_package.sv
// Shared state encoding and constants for the HWPE peripheral register target.
package hwpe_ctrl_package;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DREQ  = 3'd1,
    DWAIT = 3'd2,
    GNT   = 3'd3,
    RSP   = 3'd4
  } periph_state_e;

  localparam logic [31:0] PERIPH_ERR_DATA = 32'hBADACCE5;

endpackage

// File: rtl/hwpe_ctrl_periph_target.sv
// Peripheral-bus target that bridges one upstream periph transaction at a time
// onto a simple downstream register port, with address decode and timeout.
module hwpe_ctrl_periph_target
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned REG_AW    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                clk_i,
  input  logic                clear_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         data_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic [31:0]         r_data_o,
  output logic                r_valid_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic                reg_req_o,
  input  logic                reg_gnt_i,
  output logic                reg_we_o,
  output logic [REG_AW-1:0]   reg_addr_o,
  output logic [3:0]          reg_be_o,
  output logic [31:0]         reg_wdata_o,
  input  logic                reg_rvalid_i,
  input  logic [31:0]         reg_rdata_i,
  output logic                err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  periph_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  logic in_range;
  logic accept;
  logic timeout_hit;
  logic unused_addr_lsb;

  // Byte offset inside a word carries no meaning on a word-wide register port.
  assign unused_addr_lsb = ^add_i[1:0];
  assign in_range    = (add_i[31:REG_AW+2] == BASE_ADDR[31:REG_AW+2]);
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    id_d        = id_q;
    accept      = 1'b0;
    gnt_o       = 1'b0;
    r_valid_o   = 1'b0;
    r_data_o    = '0;
    r_id_o      = '0;
    err_o       = 1'b0;
    reg_req_o   = 1'b0;
    reg_we_o    = 1'b0;
    reg_addr_o  = '0;
    reg_be_o    = '0;
    reg_wdata_o = '0;

    case (state_q)
      IDLE: accept = 1'b1;

      DREQ: begin
        reg_req_o   = 1'b1;
        reg_we_o    = wen_i;
        reg_addr_o  = add_i[REG_AW+1:2];
        reg_be_o    = be_i;
        reg_wdata_o = data_i;
        cnt_d       = cnt_q + CNT_W'(1);
        // A handshake in the last allowed cycle still wins over the timeout.
        if (reg_gnt_i) begin
          state_d = wen_i ? GNT : DWAIT;
        end else if (timeout_hit) begin
          state_d = GNT;
          err_d   = 1'b1;
        end
      end

      DWAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (reg_rvalid_i) begin
          rdata_d = reg_rdata_i;
          state_d = GNT;
        end else if (timeout_hit) begin
          state_d = GNT;
          err_d   = 1'b1;
        end
      end

      GNT: begin
        gnt_o   = 1'b1;
        id_d    = id_i;
        state_d = RSP;
      end

      RSP: begin
        r_valid_o = 1'b1;
        r_id_o    = id_q;
        r_data_o  = err_q ? PERIPH_ERR_DATA : rdata_q;
        err_o     = err_q;
        state_d   = IDLE;
        accept    = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // RSP doubles as IDLE so a held request starts without a bubble.
    if (accept && req_i) begin
      cnt_d   = '0;
      rdata_d = '0;
      if (in_range) begin
        state_d = DREQ;
        err_d   = 1'b0;
      end else begin
        state_d = GNT;
        err_d   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_periph_target.sv
// Directed bench: a per-cycle expectation schedule derived from transaction
// timing rules, compared against the DUT on every cycle, plus literal pins.
module tb_hwpe_ctrl_periph_target;

  localparam int unsigned IDW     = 8;
  localparam int unsigned AW      = 6;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          TMO     = 256;
  localparam int          NCYC    = 2048;
  localparam logic [31:0] ERRDATA = 32'hBADACCE5;

  logic           clk = 1'b0;
  logic           clear_i;
  logic           req_i;
  logic           gnt_o;
  logic [31:0]    add_i;
  logic           wen_i;
  logic [3:0]     be_i;
  logic [31:0]    data_i;
  logic [IDW-1:0] id_i;
  logic [31:0]    r_data_o;
  logic           r_valid_o;
  logic [IDW-1:0] r_id_o;
  logic           reg_req_o;
  logic           reg_gnt_i;
  logic           reg_we_o;
  logic [AW-1:0]  reg_addr_o;
  logic [3:0]     reg_be_o;
  logic [31:0]    reg_wdata_o;
  logic           reg_rvalid_i;
  logic [31:0]    reg_rdata_i;
  logic           err_o;

  hwpe_ctrl_periph_target #(
    .ID_WIDTH (IDW),
    .REG_AW   (AW),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_i       (clk),
    .clear_i     (clear_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .add_i       (add_i),
    .wen_i       (wen_i),
    .be_i        (be_i),
    .data_i      (data_i),
    .id_i        (id_i),
    .r_data_o    (r_data_o),
    .r_valid_o   (r_valid_o),
    .r_id_o      (r_id_o),
    .reg_req_o   (reg_req_o),
    .reg_gnt_i   (reg_gnt_i),
    .reg_we_o    (reg_we_o),
    .reg_addr_o  (reg_addr_o),
    .reg_be_o    (reg_be_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_rvalid_i(reg_rvalid_i),
    .reg_rdata_i (reg_rdata_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle; anything not scheduled must read as zero.
  bit          exp_gnt [NCYC];
  bit          exp_rv  [NCYC];
  bit          exp_err [NCYC];
  bit          exp_req [NCYC];
  logic [31:0] exp_rdat[NCYC];
  logic [7:0]  exp_rid [NCYC];
  logic [31:0] exp_addr[NCYC];
  bit          exp_we  [NCYC];
  logic [3:0]  exp_be  [NCYC];
  logic [31:0] exp_wd  [NCYC];

  int n_checks = 0;
  int n_errors = 0;
  bit check_on = 1'b0;

  int          n_gnt = 0, n_rv = 0, n_req = 0;
  int          last_gnt_cyc = -1, last_rv_cyc = -1;
  logic [31:0] last_rdata = '0;
  logic [7:0]  last_rid = '0;
  logic        last_err = 1'b0;
  logic [31:0] last_reg_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      if (cyc >= NCYC) begin
        $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
        $fatal(1, "cycle budget exhausted");
      end
      chk("gnt_o",       32'(gnt_o),       32'(exp_gnt[cyc]));
      chk("r_valid_o",   32'(r_valid_o),   32'(exp_rv[cyc]));
      chk("err_o",       32'(err_o),       32'(exp_err[cyc]));
      chk("r_data_o",    r_data_o,         exp_rdat[cyc]);
      chk("r_id_o",      32'(r_id_o),      32'(exp_rid[cyc]));
      chk("reg_req_o",   32'(reg_req_o),   32'(exp_req[cyc]));
      chk("reg_we_o",    32'(reg_we_o),    32'(exp_we[cyc]));
      chk("reg_addr_o",  32'(reg_addr_o),  exp_addr[cyc]);
      chk("reg_be_o",    32'(reg_be_o),    32'(exp_be[cyc]));
      chk("reg_wdata_o", reg_wdata_o,      exp_wd[cyc]);
      if (gnt_o === 1'b1) begin
        n_gnt++;
        last_gnt_cyc = cyc;
      end
      if (r_valid_o === 1'b1) begin
        n_rv++;
        last_rv_cyc = cyc;
        last_rdata  = r_data_o;
        last_rid    = r_id_o;
        last_err    = err_o;
      end
      if (reg_req_o === 1'b1) begin
        n_req++;
        last_reg_addr = 32'(reg_addr_o);
      end
    end
  end

  task automatic mark_req(input int k, input logic [31:0] addr, input bit wen,
                          input logic [3:0] be, input logic [31:0] data);
    exp_req[k]  = 1'b1;
    exp_addr[k] = (addr >> 2) & 32'h3F;
    exp_we[k]   = wen;
    exp_be[k]   = be;
    exp_wd[k]   = data;
  endtask

  // Drives one upstream transaction starting now; gd = cycles the downstream
  // withholds its grant, rd = cycles from grant to read data, spur = cycle of
  // an extra rvalid pulse that must be ignored (-1 for none).
  task automatic run_txn(input logic [31:0] addr, input bit wen, input logic [3:0] be,
                         input logic [31:0] data, input logic [7:0] id, input int gd,
                         input int rd, input logic [31:0] rdat, input int spur,
                         output int c0);
    int c, g, gc, v;
    bit inr, err;
    logic [31:0] rsp;
    c  = cyc;
    c0 = c;
    req_i  = 1'b1;
    add_i  = addr;
    wen_i  = wen;
    be_i   = be;
    data_i = data;
    id_i   = id;
    inr = ((addr >> 8) == (BASE >> 8));
    gc  = c + 1 + gd;
    v   = gc + rd;
    err = 1'b0;
    if (!inr) begin
      g   = c + 1;
      err = 1'b1;
    end else if (gd >= TMO) begin
      g   = c + TMO + 1;
      err = 1'b1;
      for (int k = c + 1; k <= c + TMO; k++) mark_req(k, addr, wen, be, data);
    end else begin
      for (int k = c + 1; k <= gc; k++) mark_req(k, addr, wen, be, data);
      if (wen) g = gc + 1;
      else if (v <= c + TMO) g = v + 1;
      else begin
        g   = c + TMO + 1;
        err = 1'b1;
      end
    end
    rsp = err ? ERRDATA : (wen ? 32'h0 : rdat);
    exp_gnt[g]      = 1'b1;
    exp_rv[g+1]     = 1'b1;
    exp_rdat[g+1]   = rsp;
    exp_rid[g+1]    = id;
    exp_err[g+1]    = err;
    for (int k = c; k <= g; k++) begin
      reg_gnt_i    = (k == gc);
      reg_rvalid_i = (!wen && k == v) || (k == spur);
      reg_rdata_i  = (k == v) ? rdat : $urandom;
      step();
    end
    reg_gnt_i    = 1'b0;
    reg_rvalid_i = 1'b0;
    req_i        = 1'b0;
    add_i        = $urandom;
    wen_i        = 1'($urandom);
    be_i         = 4'($urandom);
    data_i       = $urandom;
    id_i         = 8'($urandom);
  endtask

  initial begin
    int c0, c1, g0, r0, q0;
    logic [31:0] wd;
    clear_i      = 1'b1;
    req_i        = 1'b0;
    add_i        = '0;
    wen_i        = 1'b0;
    be_i         = '0;
    data_i       = '0;
    id_i         = '0;
    reg_gnt_i    = 1'b0;
    reg_rvalid_i = 1'b0;
    reg_rdata_i  = '0;
    step();
    step();
    check_on = 1'b1;
    chk("rst_gnt",    32'(gnt_o),     32'h0);
    chk("rst_rvalid", 32'(r_valid_o), 32'h0);
    chk("rst_reqo",   32'(reg_req_o), 32'h0);
    chk("rst_err",    32'(err_o),     32'h0);
    chk("rst_rdata",  r_data_o,       32'h0);
    clear_i = 1'b0;
    step();

    // In-range write, downstream grants at once.
    run_txn(32'h10, 1'b1, 4'hF, 32'hCAFE0001, 8'h11, 0, 0, 32'h0, -1, c0);
    step();
    chk("w_regaddr",  last_reg_addr,               32'd4);
    chk("w_gnt_lat",  32'(last_gnt_cyc - c0),      32'd2);
    chk("w_rv_lat",   32'(last_rv_cyc - c0),       32'd3);
    chk("w_rdata",    last_rdata,                  32'h0);
    step();

    // Read with data three cycles after the grant.
    run_txn(32'h8, 1'b0, 4'hF, 32'h0, 8'h5A, 0, 3, 32'h12345678, -1, c0);
    step();
    chk("r_gnt_lat",  32'(last_gnt_cyc - c0),      32'd5);
    chk("r_rdata",    last_rdata,                  32'h12345678);
    chk("r_rid",      32'(last_rid),               32'h5A);
    step();

    // Out-of-range read: no downstream traffic, error response.
    q0 = n_req;
    run_txn(32'h1000, 1'b0, 4'hF, 32'h0, 8'h33, 0, 1, 32'h0, -1, c0);
    step();
    chk("oor_gnt_lat", 32'(last_gnt_cyc - c0),     32'd1);
    chk("oor_rdata",   last_rdata,                 32'hBADACCE5);
    chk("oor_err",     32'(last_err),              32'h1);
    chk("oor_noreq",   32'(n_req - q0),            32'd0);
    step();

    // Downstream never grants: timeout after the full DREQ window.
    q0 = n_req;
    run_txn(32'h20, 1'b1, 4'h3, 32'h0BAD0BAD, 8'h44, 300, 0, 32'h0, -1, c0);
    step();
    chk("tmo_gnt_lat", 32'(last_gnt_cyc - c0),     32'd257);
    chk("tmo_reqcnt",  32'(n_req - q0),            32'd256);
    chk("tmo_rdata",   last_rdata,                 32'hBADACCE5);
    chk("tmo_err",     32'(last_err),              32'h1);
    for (int i = 0; i < 40; i++) step();

    // Two back-to-back writes with the request held across the response.
    g0 = n_gnt;
    r0 = n_rv;
    run_txn(32'h04, 1'b1, 4'hF, 32'hAAAA5555, 8'h01, 0, 0, 32'h0, -1, c0);
    run_txn(32'h3E, 1'b1, 4'h3, 32'h5555AAAA, 8'h02, 0, 0, 32'h0, -1, c1);
    step();
    chk("b2b_start",   32'(c1 - c0),               32'd3);
    chk("b2b_gnt_lat", 32'(last_gnt_cyc - c0),     32'd5);
    chk("b2b_ngnt",    32'(n_gnt - g0),            32'd2);
    chk("b2b_nrv",     32'(n_rv - r0),             32'd2);
    chk("b2b_addr",    last_reg_addr,              32'd15);
    step();

    // Delayed grant with a stray rvalid while still requesting.
    run_txn(32'h2C, 1'b0, 4'hF, 32'h0, 8'h66, 2, 1, 32'hA5A50F0F, cyc + 1, c0);
    step();
    chk("spur_gnt_lat", 32'(last_gnt_cyc - c0),    32'd5);
    chk("spur_rdata",   last_rdata,                32'hA5A50F0F);
    step();

    // Read data in the last cycle before timeout, then one cycle too late.
    run_txn(32'h30, 1'b0, 4'hF, 32'h0, 8'h71, 0, 255, 32'h0000BEEF, -1, c0);
    step();
    chk("edge_gnt_lat", 32'(last_gnt_cyc - c0),    32'd257);
    chk("edge_rdata",   last_rdata,                32'h0000BEEF);
    chk("edge_err",     32'(last_err),             32'h0);
    step();
    run_txn(32'h34, 1'b0, 4'hF, 32'h0, 8'h72, 0, 256, 32'h0000F00D, -1, c0);
    step();
    chk("late_gnt_lat", 32'(last_gnt_cyc - c0),    32'd257);
    chk("late_rdata",   last_rdata,                32'hBADACCE5);
    chk("late_err",     32'(last_err),             32'h1);
    step();

    // Clear while waiting for read data; the late rvalid must be ignored.
    g0 = n_gnt;
    r0 = n_rv;
    c0 = cyc;
    wd = $urandom;
    req_i  = 1'b1;
    add_i  = 32'h0C;
    wen_i  = 1'b0;
    be_i   = 4'hF;
    data_i = wd;
    id_i   = 8'h77;
    mark_req(c0 + 1, 32'h0C, 1'b0, 4'hF, wd);
    step();
    reg_gnt_i = 1'b1;
    step();
    reg_gnt_i = 1'b0;
    step();
    clear_i = 1'b1;
    req_i   = 1'b0;
    step();
    clear_i      = 1'b0;
    reg_rvalid_i = 1'b1;
    reg_rdata_i  = 32'hDEADBEEF;
    step();
    reg_rvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("clr_ngnt", 32'(n_gnt - g0), 32'd0);
    chk("clr_nrv",  32'(n_rv - r0),  32'd0);

    // Target is idle again and serves a fresh write at minimum latency.
    run_txn(32'h18, 1'b1, 4'h5, 32'h01020304, 8'h99, 0, 0, 32'h0, -1, c0);
    step();
    chk("post_gnt_lat", 32'(last_gnt_cyc - c0), 32'd2);
    chk("post_rid",     32'(last_rid),          32'h99);
    for (int i = 0; i < 4; i++) step();

    check_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
